pc_stack: RTL

Program-counter register with an integrated hardware return-address stack. Sits directly downstream of the jump-target calculator:
- Loads the computed target address on a taken jump.
- On every other enabled cycle, advances the PC by one.
- Pushes the return address on CALL and pops it on RET.
- Drives the link/return address (top of stack) back to the jump-target calculator for return-relative jumps.

---
 rtl/pc_stack.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack; a request sampled at a
// rising edge is reflected on pc/lr_addr/flags right after that edge, with no handshake or backpressure.
module pc_stack #(
  parameter int              WIDTH      = 8,
  parameter int              DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             jmp_en,
  input  logic             jmp_call,
  input  logic             ret,
  input  logic [WIDTH-1:0] target_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] lr_addr,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic             push;

  // Top-of-stack and flags decode purely from registered state, so target_addr
  // may safely depend on lr_addr within the same cycle.
  always_comb begin
    pc_inc = pc_q + WIDTH'(1);
    top    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top = stack_q[i];
    end
    empty = (sp_q == '0);
    full  = (sp_q == SPW'(DEPTH));
  end

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (en) begin
      if (ret) begin
        if (!empty) begin
          pc_d = top;
          sp_d = sp_q - SPW'(1);
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (jmp_en) begin
        pc_d = target_addr;
        if (jmp_call) begin
          if (!full) begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Return address is the wrapped pc+1; popped slots are left stale.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (push && (sp_q == SPW'(i))) stack_d[i] = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_ADDR;
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign pc          = pc_q;
  assign lr_addr     = top;
  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_err   = err_q;

endmodule
